// File: rtl/roll_uart_pkg.sv
// Shared types and constants for the die-roll UART transmitter.
// ROLL_UART_TX_PARITY_EN adds an even-parity bit and the PARITY state.
package roll_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef ROLL_UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam int         MSG_BYTES  = 4;

  // Byte idx of the message for a roll: tens digit, ones digit, CR, LF.
  function automatic logic [7:0] msg_byte(input logic [4:0] roll, input logic [1:0] idx);
    logic [7:0] r8;
    logic [7:0] tens;
    logic [7:0] ones;
    r8   = {3'b000, roll};
    tens = r8 / 8'd10;
    ones = r8 % 8'd10;
    case (idx)
      2'd0:    msg_byte = ASCII_ZERO + tens;
      2'd1:    msg_byte = ASCII_ZERO + ones;
      2'd2:    msg_byte = ASCII_CR;
      default: msg_byte = ASCII_LF;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer (optional even parity under ROLL_UART_TX_PARITY_EN).
// Handshake: start is sampled in IDLE, or in the last cycle of STOP to chain bytes back-to-back.
module uart_byte_tx
  import roll_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       bit_end,
  output logic [2:0] state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      state_q;
  uart_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;

  assign state   = state_q;
  assign bit_end = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_START;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end && (bit_q == 3'd7)) begin
`ifdef ROLL_UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef ROLL_UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP:   if (bit_end) state_d = start ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shift_q[bit_q];
`ifdef ROLL_UART_TX_PARITY_EN
      ST_PARITY: tx = ^shift_q;
`endif
      default:   tx = 1'b1;
    endcase
  end

  // Data is latched at the end of the start bit, so the caller may settle it during START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) || bit_end) cnt_q <= '0;
      else                                 cnt_q <= cnt_q + 1'b1;
      if (state_d == ST_IDLE)                    bit_q <= '0;
      else if ((state_q == ST_DATA) && bit_end)  bit_q <= bit_q + 3'd1;
      if ((state_q == ST_START) && bit_end) shift_q <= data;
    end
  end

endmodule

// File: rtl/roll_uart_tx.sv
// Die-roll reporter: captures a 0..31 roll and transmits it as "NN\r\n" over UART.
// ROLL_UART_TX_PARITY_EN enables an even-parity bit per byte in the serializer.
module roll_uart_tx
  import roll_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [4:0] i_dieRoll,
  input  logic       i_roll_valid,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_uart
);

  localparam logic [1:0] LAST_BYTE = 2'(MSG_BYTES - 1);

  logic       busy_q;
  logic [4:0] roll_q;
  logic [1:0] byte_idx_q;
  logic       accept;
  logic       byte_done;
  logic       tx_start;
  logic       bit_end;
  logic [2:0] tx_state;
  logic [7:0] tx_byte;

  assign accept    = i_roll_valid && !busy_q;
  assign byte_done = bit_end && (tx_state == ST_STOP);
  // Chaining the next start into the last stop cycle keeps bytes gap-free.
  assign tx_start  = accept || (byte_done && (byte_idx_q != LAST_BYTE));
  assign tx_byte   = msg_byte(roll_q, byte_idx_q);
  assign o_ready   = !busy_q;
  assign o_busy    = busy_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      busy_q     <= 1'b0;
      roll_q     <= '0;
      byte_idx_q <= '0;
    end else if (accept) begin
      busy_q     <= 1'b1;
      roll_q     <= i_dieRoll;
      byte_idx_q <= '0;
    end else if (byte_done) begin
      if (byte_idx_q == LAST_BYTE) begin
        busy_q     <= 1'b0;
        byte_idx_q <= '0;
      end else begin
        byte_idx_q <= byte_idx_q + 2'd1;
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk    (i_clk),
    .rst_n  (i_reset_n),
    .start  (tx_start),
    .data   (tx_byte),
    .tx     (o_uart),
    .bit_end(bit_end),
    .state  (tx_state)
  );

endmodule
